mixer_dump_reader: RTL and testbench

//   Read side of the integrate-and-dump complex mixer. It uses the same sload

---
 rtl/mixer_dump_reader.sv | 127 ++++++++++++
 tb/tb_mixer_dump_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mixer_dump_reader.sv
// mixer_dump_reader: captures integrate-and-dump mixer sums at window end,
// rounds/saturates them, tags them and queues them on a valid/ready FIFO.
module mixer_dump_reader #(
   parameter int SIZEOUT      = 40,
   parameter int DWIDTH       = 16,
   parameter int SHIFT        = 8,
   parameter int LOAD_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int TAGW         = 8,
   localparam int AW          = $clog2(FIFO_DEPTH),
   localparam int LW          = AW + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sload,
   input  logic signed [SIZEOUT-1:0] pr,
   input  logic signed [SIZEOUT-1:0] pi,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DWIDTH-1:0]  out_re,
   output logic signed [DWIDTH-1:0]  out_im,
   output logic [TAGW-1:0]           out_tag,
   output logic                      out_sat,
   output logic                      overflow,
   input  logic                      overflow_clr,
   output logic [LW-1:0]             fifo_level
);
   localparam logic signed [SIZEOUT:0] RND  = SHIFT > 0 ? (SIZEOUT+1)'(1) << (SHIFT-1) : '0;
   localparam logic signed [SIZEOUT:0] MAXV = (SIZEOUT+1)'((1 << (DWIDTH-1)) - 1);
   localparam logic signed [SIZEOUT:0] MINV = -MAXV - 1;

   function automatic logic [DWIDTH:0] clamp(input logic signed [SIZEOUT:0] r);
      return r > MAXV ? {1'b1, MAXV[DWIDTH-1:0]} :
             r < MINV ? {1'b1, MINV[DWIDTH-1:0]} : {1'b0, r[DWIDTH-1:0]};
   endfunction

   logic [LOAD_LATENCY-1:0]   dl;
   logic                      sload_d, first_seen, cap_v, res_v, res_sat;
   logic [TAGW-1:0]           tag, cap_tag, res_tag;
   logic signed [SIZEOUT-1:0] cap_re, cap_im;
   logic signed [SIZEOUT:0]   sum_re, sum_im;
   logic [DWIDTH:0]           cr, ci;
   logic [DWIDTH-1:0]         res_re, res_im;

   assign sload_d = dl[LOAD_LATENCY-1];
   assign sum_re  = cap_re + RND;
   assign sum_im  = cap_im + RND;
   assign cr      = clamp(sum_re >>> SHIFT);
   assign ci      = clamp(sum_im >>> SHIFT);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dl         <= '0;
         first_seen <= 1'b0;
         tag        <= '0;
         cap_v      <= 1'b0;
         cap_re     <= '0;
         cap_im     <= '0;
         cap_tag    <= '0;
         res_v      <= 1'b0;
         res_re     <= '0;
         res_im     <= '0;
         res_tag    <= '0;
         res_sat    <= 1'b0;
      end else begin
         dl    <= LOAD_LATENCY'({dl, sload});
         cap_v <= sload_d & first_seen;
         if (sload_d) begin
            cap_re     <= pr;
            cap_im     <= pi;
            cap_tag    <= tag;
            first_seen <= 1'b1;
            if (first_seen) tag <= tag + 1'b1;
         end
         res_v   <= cap_v;
         res_re  <= cr[DWIDTH-1:0];
         res_im  <= ci[DWIDTH-1:0];
         res_sat <= cr[DWIDTH] | ci[DWIDTH];
         res_tag <= cap_tag;
      end

   logic [DWIDTH-1:0] mem_re  [FIFO_DEPTH];
   logic [DWIDTH-1:0] mem_im  [FIFO_DEPTH];
   logic [TAGW-1:0]   mem_tag [FIFO_DEPTH];
   logic              mem_sat [FIFO_DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [LW-1:0]     level;
   logic              full, pop, wr, drop;

   // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
   assign full = level == LW'(FIFO_DEPTH);
   assign pop  = out_valid & out_ready;
   assign wr   = res_v & (~full | pop);
   assign drop = res_v & full & ~pop;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         level    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_re[i]  <= '0;
            mem_im[i]  <= '0;
            mem_tag[i] <= '0;
            mem_sat[i] <= 1'b0;
         end
      end else begin
         if (wr) begin
            mem_re[wp]  <= res_re;
            mem_im[wp]  <= res_im;
            mem_tag[wp] <= res_tag;
            mem_sat[wp] <= res_sat;
            wp          <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         level    <= level + LW'(wr) - LW'(pop);
         overflow <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
      end

   assign out_valid  = level != '0;
   assign out_re     = mem_re[rp];
   assign out_im     = mem_im[rp];
   assign out_tag    = mem_tag[rp];
   assign out_sat    = mem_sat[rp];
   assign fifo_level = level;
endmodule

// File: tb/tb_mixer_dump_reader.sv
// tb_mixer_dump_reader: directed checks of capture, rounding, saturation,
// tagging, FIFO backpressure/overflow and asynchronous reset.
module tb_mixer_dump_reader;
   logic               clk = 1'b0;
   logic               rst_n, sload, out_ready, overflow_clr;
   logic signed [39:0] pr, pi;
   logic               out_valid, out_sat, overflow;
   logic signed [15:0] out_re, out_im;
   logic [7:0]         out_tag;
   logic [2:0]         fifo_level;
   int                 n_chk = 0;
   int                 n_fail = 0;

   mixer_dump_reader dut (
      .clk(clk), .rst_n(rst_n), .sload(sload), .pr(pr), .pi(pi),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_tag(out_tag), .out_sat(out_sat), .overflow(overflow),
      .overflow_clr(overflow_clr), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string t, input logic signed [63:0] o, input logic signed [63:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", t, o, e);
      end
   endtask

   task automatic tk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge just after the capture edge E.
   task automatic pulse(input logic signed [39:0] a, input logic signed [39:0] b);
      @(negedge clk);
      sload = 1'b1; pr = a; pi = b;
      @(negedge clk);
      sload = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_all();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_idle(input string t);
      chk({t, "_valid"}, out_valid, 0);
      chk({t, "_level"}, fifo_level, 0);
      chk({t, "_ovf"}, overflow, 0);
      chk({t, "_re"}, out_re, 0);
      chk({t, "_tag"}, out_tag, 0);
   endtask

   initial begin
      rst_n = 1'b0; sload = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0; pr = '0; pi = '0;
      tk(2);
      chk_idle("rst_hold");
      rst_n = 1'b1;
      tk(1);
      chk_idle("rst_rel");
      pulse(0, 0);
      tk(3);
      chk("first_discard_valid", out_valid, 0);
      pulse(256, -256);
      tk(2);
      chk("t1_valid", out_valid, 1);
      chk("t1_re", out_re, 1);
      chk("t1_im", out_im, -1);
      chk("t1_tag", out_tag, 0);
      chk("t1_sat", out_sat, 0);
      out_ready = 1'b1; tk(1); out_ready = 1'b0;
      chk("t1_pop_level", fifo_level, 0);

      pulse(384, -384);
      tk(1);
      chk("t2_valid_e1", out_valid, 0);
      tk(1);
      chk("t2_valid_e2", out_valid, 1);
      chk("t2_re", out_re, 2);
      chk("t2_im", out_im, -1);
      chk("t2_sat", out_sat, 0);
      chk("t2_tag", out_tag, 1);
      out_ready = 1'b1; tk(1); out_ready = 1'b0;

      pulse(40'sd1073741824, -40'sd1073741824);
      tk(2);
      chk("t3_re", out_re, 32767);
      chk("t3_im", out_im, -32768);
      chk("t3_sat", out_sat, 1);
      chk("t3_tag", out_tag, 2);
      out_ready = 1'b1; tk(1); out_ready = 1'b0;

      reset_all();
      pulse(0, 0);
      for (int k = 0; k < 6; k++) pulse(40'(k * 256), 0);
      tk(2);
      chk("t4_level", fifo_level, 4);
      chk("t4_ovf", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_drain_tag", out_tag, i);
         chk("t4_drain_re", out_re, i);
         tk(1);
      end
      chk("t4_empty", out_valid, 0);
      pulse(256, 0);
      tk(2);
      chk("t4_gap_valid", out_valid, 1);
      chk("t4_gap_tag", out_tag, 6);
      chk("t4_ovf_sticky", overflow, 1);
      overflow_clr = 1'b1; tk(1); overflow_clr = 1'b0;
      chk("t4_ovf_clr", overflow, 0);
      tk(1);

      sload = 1'b1; pr = 256; pi = 0;
      tk(3);
      sload = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tk(1);
         chk("t5_b2b_valid", out_valid, 1);
         chk("t5_b2b_tag", out_tag, 7 + i);
         chk("t5_b2b_level", fifo_level, 1);
      end
      tk(1);
      chk("t5_b2b_done", fifo_level, 0);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) pulse(256, 0);
      tk(2);
      chk("t5_full", fifo_level, 4);
      chk("t5_full_ovf", overflow, 0);
      @(negedge clk); sload = 1'b1;
      @(negedge clk); sload = 1'b0;
      tk(2); out_ready = 1'b1;
      tk(1); out_ready = 1'b0;
      chk("t5_pushpop_level", fifo_level, 4);
      chk("t5_pushpop_ovf", overflow, 0);
      chk("t5_pushpop_head", out_tag, 11);

      out_ready = 1'b1; tk(2); out_ready = 1'b0;
      chk("t6_pre_level", fifo_level, 2);
      chk("t6_pre_head", out_tag, 13);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", out_valid, 0);
      chk("t6_async_level", fifo_level, 0);
      @(negedge clk); rst_n = 1'b1;
      pulse(0, 0);
      tk(2);
      chk("t6_discard", out_valid, 0);
      pulse(256, -256);
      tk(2);
      chk("t6_valid", out_valid, 1);
      chk("t6_tag", out_tag, 0);
      chk("t6_re", out_re, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
